// File: rtl/concat_pkg.sv
// Shared definitions for the three-source frame concatenating scheduler.
//
// Contents:
//   state_e       : scheduler state (idle or one of the three segments).
//   SEG_*         : encodings presented on o_seg.
//   DEF_LEN1..3   : default segment lengths of the standard frame.
//   pick_segment  : first segment whose "nonzero length" flag is set.
//   state_to_seg  : maps a state onto its o_seg encoding.
package concat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEG1 = 2'd1,
    ST_SEG2 = 2'd2,
    ST_SEG3 = 2'd3
  } state_e;

  localparam logic [1:0] SEG_IDLE = 2'd0;
  localparam logic [1:0] SEG_1    = 2'd1;
  localparam logic [1:0] SEG_2    = 2'd2;
  localparam logic [1:0] SEG_3    = 2'd3;

  localparam int DEF_LEN1 = 144;
  localparam int DEF_LEN2 = 12;
  localparam int DEF_LEN3 = 132;

  // Lowest-numbered segment whose flag is set; ST_IDLE when none is.
  // Used both for frame entry and for skipping zero-length segments.
  function automatic state_e pick_segment(input logic nz1,
                                          input logic nz2,
                                          input logic nz3);
    state_e s;
    if (nz1)      s = ST_SEG1;
    else if (nz2) s = ST_SEG2;
    else if (nz3) s = ST_SEG3;
    else          s = ST_IDLE;
    return s;
  endfunction

  function automatic logic [1:0] state_to_seg(input state_e s);
    logic [1:0] seg;
    case (s)
      ST_SEG1: seg = SEG_1;
      ST_SEG2: seg = SEG_2;
      ST_SEG3: seg = SEG_3;
      default: seg = SEG_IDLE;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/concat_frame_scheduler.sv
// Concatenates three word sources into one output stream, frame by frame.
// A frame is len1 words of source 1, then len2 words of source 2, then
// len3 words of source 3; zero-length segments are skipped without an idle
// cycle. Lengths are captured when the frame starts.
//
// Handshake (all streams): a word moves on a rising edge where valid and
// ready are both 1. valid never depends on ready. The selected source is
// passed straight through with no register stage: o_out_data/o_out_valid
// come from the active source, and only that source sees i_out_ready on its
// o_src_ready bit; the other two ready bits are held at 0.
//
// Ports:
//   i_clock, i_reset_n           clock, async active-low reset
//   i_enable                     allows a new frame to start from idle
//   i_len1..i_len3   [LEN_W]     segment lengths, sampled at frame start
//   i_src1..3_data   [WIDTH]     source words
//   i_src_valid      [3]         per-source valid (bit n-1 = source n)
//   o_src_ready      [3]         per-source ready
//   o_out_data/valid, i_out_ready  output stream
//   o_out_first/o_out_last       frame's first / final word is presented
//   o_seg            [2]         active segment (0 idle, 1..3 source)
//   o_busy                       frame in progress
//   o_frame_count    [FCNT_W]    completed frames, wraps
module concat_frame_scheduler
  import concat_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LEN_W  = 12,
  parameter int FCNT_W = 16
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic [LEN_W-1:0]  i_len1,
  input  logic [LEN_W-1:0]  i_len2,
  input  logic [LEN_W-1:0]  i_len3,
  input  logic [WIDTH-1:0]  i_src1_data,
  input  logic [WIDTH-1:0]  i_src2_data,
  input  logic [WIDTH-1:0]  i_src3_data,
  input  logic [2:0]        i_src_valid,
  output logic [2:0]        o_src_ready,
  output logic [WIDTH-1:0]  o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_first,
  output logic              o_out_last,
  output logic [1:0]        o_seg,
  output logic              o_busy,
  output logic [FCNT_W-1:0] o_frame_count
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LEN_W-1:0]    len1_q, len1_d;
  logic [LEN_W-1:0]    len2_q, len2_d;
  logic [LEN_W-1:0]    len3_q, len3_d;
  logic [FCNT_W-1:0]   frame_count_q, frame_count_d;
  logic                first_q, first_d;

  logic                fire;
  logic                last_word;
  logic                start;
  state_e              entry_state;
  state_e              after_seg;

  // Length belonging to a segment state, chosen from a given length set.
  function automatic logic [LEN_W-1:0] seg_len(input state_e s,
                                               input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b,
                                               input logic [LEN_W-1:0] c);
    logic [LEN_W-1:0] l;
    case (s)
      ST_SEG1: l = a;
      ST_SEG2: l = b;
      ST_SEG3: l = c;
      default: l = '0;
    endcase
    return l;
  endfunction

  // Source mux: zero-latency pass-through of the active source.
  always_comb begin
    o_out_data  = '0;
    o_out_valid = 1'b0;
    o_src_ready = 3'b000;
    case (state_q)
      ST_SEG1: begin
        o_out_data     = i_src1_data;
        o_out_valid    = i_src_valid[0];
        o_src_ready[0] = i_out_ready;
      end
      ST_SEG2: begin
        o_out_data     = i_src2_data;
        o_out_valid    = i_src_valid[1];
        o_src_ready[1] = i_out_ready;
      end
      ST_SEG3: begin
        o_out_data     = i_src3_data;
        o_out_valid    = i_src_valid[2];
        o_src_ready[2] = i_out_ready;
      end
      default: ;
    endcase
  end

  // Segment that follows the current one, skipping latched zero lengths.
  always_comb begin
    after_seg = ST_IDLE;
    case (state_q)
      ST_SEG1: after_seg = pick_segment(1'b0, len2_q != '0, len3_q != '0);
      ST_SEG2: after_seg = pick_segment(1'b0, 1'b0, len3_q != '0);
      default: after_seg = ST_IDLE;
    endcase
  end

  assign fire        = o_out_valid & i_out_ready;
  assign last_word   = (rem_q == LEN_W'(1));
  // A nonzero sum of unsigned lengths is the same as any length nonzero,
  // and the OR form cannot overflow.
  assign start       = (state_q == ST_IDLE) & i_enable &
                       ((i_len1 | i_len2 | i_len3) != '0);
  assign entry_state = pick_segment(i_len1 != '0, i_len2 != '0, i_len3 != '0);

  // Next-state logic. start only occurs in idle and fire only in a segment
  // (valid is 0 in idle), so the two branches never overlap; this is also
  // why a frame can never begin on the edge where the previous one ends.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    len1_d        = len1_q;
    len2_d        = len2_q;
    len3_d        = len3_q;
    frame_count_d = frame_count_q;
    first_d       = first_q;
    if (start) begin
      len1_d  = i_len1;
      len2_d  = i_len2;
      len3_d  = i_len3;
      state_d = entry_state;
      rem_d   = seg_len(entry_state, i_len1, i_len2, i_len3);
      first_d = 1'b1;
    end else if (fire) begin
      first_d = 1'b0;
      if (last_word) begin
        state_d = after_seg;
        rem_d   = seg_len(after_seg, len1_q, len2_q, len3_q);
        if (after_seg == ST_IDLE) begin
          frame_count_d = frame_count_q + FCNT_W'(1);
        end
      end else begin
        rem_d = rem_q - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      rem_q         <= '0;
      len1_q        <= '0;
      len2_q        <= '0;
      len3_q        <= '0;
      frame_count_q <= '0;
      first_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      len1_q        <= len1_d;
      len2_q        <= len2_d;
      len3_q        <= len3_d;
      frame_count_q <= frame_count_d;
      first_q       <= first_d;
    end
  end

  // first_q stays set until the frame's first word is accepted, so first
  // tracks the word rather than the cycle.
  assign o_out_first   = o_out_valid & first_q;
  assign o_out_last    = o_out_valid & last_word & (state_q != ST_IDLE) &
                         (after_seg == ST_IDLE);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_seg         = state_to_seg(state_q);
  assign o_frame_count = frame_count_q;

endmodule

// File: tb/tb_concat_frame_scheduler.sv
// Directed bench for concat_frame_scheduler. Inputs are driven 1 time unit
// after the rising edge; outputs are captured on the falling edge.
module tb_concat_frame_scheduler;
  import concat_pkg::*;

  localparam int WIDTH  = 8;
  localparam int LEN_W  = 12;
  localparam int FCNT_W = 16;

  // ---------------- clock / reset / DUT ----------------
  logic              i_clock = 1'b0;
  logic              i_reset_n = 1'b0;
  logic              i_enable = 1'b0;
  logic [LEN_W-1:0]  i_len1 = '0, i_len2 = '0, i_len3 = '0;
  logic [WIDTH-1:0]  i_src1_data, i_src2_data, i_src3_data;
  logic [2:0]        i_src_valid = 3'b000;
  logic [2:0]        o_src_ready;
  logic [WIDTH-1:0]  o_out_data;
  logic              o_out_valid;
  logic              i_out_ready = 1'b0;
  logic              o_out_first, o_out_last;
  logic [1:0]        o_seg;
  logic              o_busy;
  logic [FCNT_W-1:0] o_frame_count;

  always #5 i_clock = ~i_clock;

  concat_frame_scheduler #(.WIDTH(WIDTH), .LEN_W(LEN_W), .FCNT_W(FCNT_W)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_len1(i_len1), .i_len2(i_len2), .i_len3(i_len3),
    .i_src1_data(i_src1_data), .i_src2_data(i_src2_data), .i_src3_data(i_src3_data),
    .i_src_valid(i_src_valid), .o_src_ready(o_src_ready),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_first(o_out_first), .o_out_last(o_out_last), .o_seg(o_seg),
    .o_busy(o_busy), .o_frame_count(o_frame_count)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int exp_fc = 0;
  int cyc = 0;

  always @(posedge i_clock) cyc <= cyc + 1;

  // ---------------- source model ----------------
  // Each source emits an incrementing index; sources are told apart by an
  // offset (src1: idx, src2: 0x90+idx, src3: 0x40+idx).
  logic [WIDTH-1:0] src_idx [3];
  logic             src_clr = 1'b1;

  always @(posedge i_clock) begin
    for (int n = 0; n < 3; n++) begin
      if (src_clr) src_idx[n] <= '0;
      else if (i_src_valid[n] && o_src_ready[n]) src_idx[n] <= src_idx[n] + 8'd1;
    end
  end

  assign i_src1_data = src_idx[0];
  assign i_src2_data = 8'h90 + src_idx[1];
  assign i_src3_data = 8'h40 + src_idx[2];

  // ---------------- capture / scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [1:0]       exp_seg[$];
  logic [WIDTH-1:0] got_q[$];
  logic [1:0]       got_seg[$];
  int               got_cyc[$];
  int               got_first[$];
  int               got_last[$];
  bit               collect_en = 1'b0;
  int               bad_hs = 0;
  int               seg2_seen = 0;
  logic [2:0]       exp_rdy;
  logic             exp_vld;

  always @(negedge i_clock) begin
    if (collect_en) begin
      exp_rdy = (o_seg != 2'd0) ? (3'(i_out_ready) << (o_seg - 2'd1)) : 3'b000;
      exp_vld = (o_seg != 2'd0) ? i_src_valid[o_seg - 2'd1] : 1'b0;
      if (o_src_ready !== exp_rdy || o_out_valid !== exp_vld) bad_hs++;
      if (o_seg == 2'd2) seg2_seen++;
      if (o_out_valid && i_out_ready) begin
        if (o_out_first) got_first.push_back(got_q.size());
        if (o_out_last)  got_last.push_back(got_q.size());
        got_q.push_back(o_out_data);
        got_seg.push_back(o_seg);
        got_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  task automatic clear_sources();
    src_clr = 1'b1;
    tick(1);
    src_clr = 1'b0;
  endtask

  task automatic build_exp(input int l1, input int l2, input int l3);
    exp_q.delete();
    exp_seg.delete();
    for (int k = 0; k < l1; k++) begin exp_q.push_back(WIDTH'(k));         exp_seg.push_back(2'd1); end
    for (int k = 0; k < l2; k++) begin exp_q.push_back(WIDTH'(8'h90 + k)); exp_seg.push_back(2'd2); end
    for (int k = 0; k < l3; k++) begin exp_q.push_back(WIDTH'(8'h40 + k)); exp_seg.push_back(2'd3); end
  endtask

  task automatic start_capture();
    got_q.delete(); got_seg.delete(); got_cyc.delete();
    got_first.delete(); got_last.delete();
    bad_hs = 0;
    seg2_seen = 0;
    collect_en = 1'b1;
  endtask

  // Pulses i_enable for one edge so exactly one frame starts.
  task automatic launch(input int l1, input int l2, input int l3);
    i_len1 = LEN_W'(l1); i_len2 = LEN_W'(l2); i_len3 = LEN_W'(l3);
    i_enable = 1'b1;
    tick(1);
    i_enable = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, output bit timed_out);
    int c;
    c = 0;
    timed_out = 1'b0;
    while (got_q.size() < n) begin
      @(posedge i_clock);
      c++;
      if (c > budget) begin timed_out = 1'b1; break; end
    end
    #1;
  endtask

  function automatic int data_errs();
    int e = 0;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      if (got_q[k] !== exp_q[k]) e++;
    return e;
  endfunction

  function automatic int seg_errs();
    int e = 0;
    for (int k = 0; k < exp_seg.size() && k < got_seg.size(); k++)
      if (got_seg[k] !== exp_seg[k]) e++;
    return e;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    i_len1 = 12'd5; i_len2 = 12'd5; i_len3 = 12'd5;
    i_src_valid = 3'b111; i_out_ready = 1'b1; i_enable = 1'b1;
    tick(3);
    tests_run++; if (o_src_ready !== 3'b000) begin tests_failed++; $display("FAIL reset_ready: got %b expected 000", o_src_ready); end
    tests_run++; if (o_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", o_out_valid); end
    tests_run++; if (o_out_first !== 1'b0 || o_out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_first_last: got %b%b expected 00", o_out_first, o_out_last); end
    tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    tests_run++; if (o_seg !== SEG_IDLE) begin tests_failed++; $display("FAIL reset_seg: got %0d expected 0", o_seg); end
    tests_run++; if (o_frame_count !== 16'h0000) begin tests_failed++; $display("FAIL reset_fcount: got %0h expected 0", o_frame_count); end
    i_enable = 1'b0;
    i_reset_n = 1'b1;
    tick(2);
    tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset: busy %b expected 0", o_busy); end
  endtask

  task automatic test_full_frame();
    bit to;
    clear_sources();
    build_exp(DEF_LEN1, DEF_LEN2, DEF_LEN3);
    start_capture();
    launch(DEF_LEN1, DEF_LEN2, DEF_LEN3);
    wait_words(288, 2000, to);
    collect_en = 1'b0;
    exp_fc++;
    tests_run++; if (to) begin tests_failed++; $display("FAIL full_timeout: got %0d words expected 288", got_q.size()); end
    tests_run++; if (got_q.size() !== 288) begin tests_failed++; $display("FAIL full_count: got %0d expected 288", got_q.size()); end
    tests_run++; if (data_errs() !== 0) begin tests_failed++; $display("FAIL full_data: got %0d bad words expected 0", data_errs()); end
    tests_run++; if (seg_errs() !== 0) begin tests_failed++; $display("FAIL full_seg: got %0d bad segs expected 0", seg_errs()); end
    tests_run++; if (got_first.size() !== 1 || got_first[0] !== 0) begin tests_failed++; $display("FAIL full_first: got %0d flags at %0d expected 1 at 0", got_first.size(), got_first[0]); end
    tests_run++; if (got_last.size() !== 1 || got_last[0] !== 287) begin tests_failed++; $display("FAIL full_last: got %0d flags at %0d expected 1 at 287", got_last.size(), got_last[0]); end
    tests_run++; if (got_cyc[287] - got_cyc[0] !== 287) begin tests_failed++; $display("FAIL full_consecutive: got span %0d expected 287", got_cyc[287] - got_cyc[0]); end
    tests_run++; if (o_frame_count !== FCNT_W'(exp_fc)) begin tests_failed++; $display("FAIL full_fcount: got %0h expected %0h", o_frame_count, exp_fc); end
    tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL full_idle: busy %b expected 0", o_busy); end
    tests_run++; if (bad_hs !== 0) begin tests_failed++; $display("FAIL full_handshake: got %0d bad cycles expected 0", bad_hs); end
  endtask

  task automatic test_skip_seg();
    bit to;
    clear_sources();
    build_exp(2, 0, 3);
    start_capture();
    launch(2, 0, 3);
    wait_words(5, 100, to);
    tick(3);
    collect_en = 1'b0;
    exp_fc++;
    tests_run++; if (to || got_q.size() !== 5) begin tests_failed++; $display("FAIL skip_count: got %0d expected 5", got_q.size()); end
    tests_run++; if (data_errs() !== 0) begin tests_failed++; $display("FAIL skip_data: got %0d bad words expected 0", data_errs()); end
    tests_run++; if (seg2_seen !== 0) begin tests_failed++; $display("FAIL skip_seg2: got %0d cycles with seg 2 expected 0", seg2_seen); end
    tests_run++; if (got_cyc[4] - got_cyc[0] !== 4) begin tests_failed++; $display("FAIL skip_no_gap: got span %0d expected 4", got_cyc[4] - got_cyc[0]); end
    tests_run++; if (got_last.size() !== 1 || got_last[0] !== 4) begin tests_failed++; $display("FAIL skip_last: got %0d flags at %0d expected 1 at 4", got_last.size(), got_last[0]); end
  endtask

  task automatic test_random_gaps();
    int c;
    clear_sources();
    build_exp(4, 4, 4);
    start_capture();
    i_src_valid = 3'b111; i_out_ready = 1'b1;
    launch(4, 4, 4);
    c = 0;
    while (got_q.size() < 12 && c < 500) begin
      i_out_ready = 1'($urandom_range(0, 1));
      i_src_valid = 3'($urandom_range(0, 7));
      @(posedge i_clock);
      #1;
      c++;
    end
    i_out_ready = 1'b1;
    i_src_valid = 3'b111;
    tick(2);
    collect_en = 1'b0;
    exp_fc++;
    tests_run++; if (got_q.size() !== 12) begin tests_failed++; $display("FAIL gaps_count: got %0d expected 12", got_q.size()); end
    tests_run++; if (data_errs() !== 0) begin tests_failed++; $display("FAIL gaps_data: got %0d bad words expected 0", data_errs()); end
    tests_run++; if (seg_errs() !== 0) begin tests_failed++; $display("FAIL gaps_seg: got %0d bad segs expected 0", seg_errs()); end
    tests_run++; if (bad_hs !== 0) begin tests_failed++; $display("FAIL gaps_handshake: got %0d bad cycles expected 0", bad_hs); end
    tests_run++; if (got_first.size() !== 1 || got_last.size() !== 1 || got_last[0] !== 11) begin tests_failed++; $display("FAIL gaps_flags: got first %0d last %0d expected 1 1", got_first.size(), got_last.size()); end
    tests_run++; if (o_frame_count !== FCNT_W'(exp_fc)) begin tests_failed++; $display("FAIL gaps_fcount: got %0h expected %0h", o_frame_count, exp_fc); end
  endtask

  task automatic test_enable_drop();
    bit to;
    int busy_seen;
    clear_sources();
    build_exp(DEF_LEN1, DEF_LEN2, DEF_LEN3);
    start_capture();
    i_len1 = LEN_W'(DEF_LEN1); i_len2 = LEN_W'(DEF_LEN2); i_len3 = LEN_W'(DEF_LEN3);
    i_enable = 1'b1;
    wait_words(10, 100, to);
    i_enable = 1'b0;
    i_len1 = 12'd1; i_len2 = 12'd1; i_len3 = 12'd1;
    wait_words(288, 2000, to);
    collect_en = 1'b0;
    exp_fc++;
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clock);
      if (o_busy) busy_seen++;
    end
    tick(1);
    tests_run++; if (to || got_q.size() !== 288) begin tests_failed++; $display("FAIL drop_count: got %0d expected 288", got_q.size()); end
    tests_run++; if (data_errs() !== 0) begin tests_failed++; $display("FAIL drop_data: got %0d bad words expected 0", data_errs()); end
    tests_run++; if (seg_errs() !== 0) begin tests_failed++; $display("FAIL drop_seg: got %0d bad segs expected 0", seg_errs()); end
    tests_run++; if (busy_seen !== 0) begin tests_failed++; $display("FAIL drop_idle_held: got %0d busy cycles expected 0", busy_seen); end
    tests_run++; if (o_frame_count !== FCNT_W'(exp_fc)) begin tests_failed++; $display("FAIL drop_fcount: got %0h expected %0h", o_frame_count, exp_fc); end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    clear_sources();
    start_capture();
    launch(DEF_LEN1, DEF_LEN2, DEF_LEN3);
    wait_words(50, 200, to);
    #2;
    i_reset_n = 1'b0;
    #1;
    tests_run++; if (o_out_valid !== 1'b0 || o_src_ready !== 3'b000) begin tests_failed++; $display("FAIL rst_mid_hs: got valid %b ready %b expected 0 000", o_out_valid, o_src_ready); end
    tests_run++; if (o_busy !== 1'b0 || o_seg !== SEG_IDLE) begin tests_failed++; $display("FAIL rst_mid_state: got busy %b seg %0d expected 0 0", o_busy, o_seg); end
    tests_run++; if (o_frame_count !== 16'h0000) begin tests_failed++; $display("FAIL rst_mid_fcount: got %0h expected 0", o_frame_count); end
    tests_run++; if (o_out_first !== 1'b0 || o_out_last !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_flags: got %b%b expected 00", o_out_first, o_out_last); end
    collect_en = 1'b0;
    exp_fc = 0;
    tick(2);
    i_reset_n = 1'b1;
    tick(2);
    tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_resume: busy %b expected 0", o_busy); end
    clear_sources();
    build_exp(3, 2, 1);
    start_capture();
    launch(3, 2, 1);
    wait_words(6, 100, to);
    collect_en = 1'b0;
    exp_fc++;
    tests_run++; if (to || got_q.size() !== 6) begin tests_failed++; $display("FAIL rst_new_count: got %0d expected 6", got_q.size()); end
    tests_run++; if (got_seg[0] !== 2'd1 || got_q[0] !== 8'h00 || got_first.size() !== 1 || got_first[0] !== 0) begin tests_failed++; $display("FAIL rst_new_first: got seg %0d data %0h expected 1 00", got_seg[0], got_q[0]); end
    tests_run++; if (data_errs() !== 0) begin tests_failed++; $display("FAIL rst_new_data: got %0d bad words expected 0", data_errs()); end
    tests_run++; if (o_frame_count !== FCNT_W'(exp_fc)) begin tests_failed++; $display("FAIL rst_new_fcount: got %0h expected %0h", o_frame_count, exp_fc); end
  endtask

  // Enable held high: frames of one word, separated by one idle cycle each.
  task automatic test_back_to_back();
    logic [5:0] pat;
    clear_sources();
    i_len1 = 12'd1; i_len2 = 12'd0; i_len3 = 12'd0;
    i_enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clock);
      pat[k] = o_busy;
    end
    tick(1);
    i_enable = 1'b0;
    tick(2);
    exp_fc += 3;
    tests_run++; if (pat !== 6'b101010) begin tests_failed++; $display("FAIL b2b_idle_gap: got busy pattern %b expected 101010", pat); end
    tests_run++; if (o_frame_count !== FCNT_W'(exp_fc)) begin tests_failed++; $display("FAIL b2b_fcount: got %0h expected %0h", o_frame_count, exp_fc); end
  endtask

  task automatic test_wrap();
    bit to;
    force dut.frame_count_q = 16'hFFFE;
    #1;
    release dut.frame_count_q;
    tick(1);
    clear_sources();
    start_capture();
    launch(1, 0, 0);
    wait_words(1, 50, to);
    tests_run++; if (to || o_frame_count !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_ffff: got %0h expected ffff", o_frame_count); end
    tick(1);
    start_capture();
    launch(0, 2, 0);
    wait_words(2, 50, to);
    collect_en = 1'b0;
    tests_run++; if (to || o_frame_count !== 16'h0000) begin tests_failed++; $display("FAIL wrap_0000: got %0h expected 0000", o_frame_count); end
  endtask

  initial begin
    test_reset();
    src_clr = 1'b0;
    test_full_frame();
    test_skip_seg();
    test_random_gaps();
    test_enable_drop();
    test_reset_mid_frame();
    test_back_to_back();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
